// File: rtl/stack_arbiter.sv
// Two-requester round-robin front end for a single-ported stack.
// One transaction in flight; every output is driven straight from a register.
module stack_arbiter #(
  parameter int DATA_WIDTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_A,
  input  logic                  REQ_B,
  input  logic                  OP_A,
  input  logic                  OP_B,
  input  logic [DATA_WIDTH-1:0] WDATA_A,
  input  logic [DATA_WIDTH-1:0] WDATA_B,
  output logic                  ACK_A,
  output logic                  ACK_B,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  ERR,
  output logic                  BUSY,
  output logic                  STK_PUSH,
  output logic                  STK_POP,
  output logic [DATA_WIDTH-1:0] STK_DATA_IN,
  input  logic [DATA_WIDTH-1:0] STK_DATA_OUT,
  input  logic                  STK_FULL,
  input  logic                  STK_EMPTY
);

  typedef enum logic [1:0] {IDLE, CMD, SETTLE, RESP} state_e;

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;    // 1 = requester B
  logic                  last_q, last_d;  // 1 = B was served last
  logic                  op_q, op_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic                  err_q, err_d, busy_q, busy_d;
  logic                  push_q, push_d, pop_q, pop_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, sdin_q, sdin_d;
  logic                  win, win_op;
  logic [DATA_WIDTH-1:0] win_data;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    err_d    = 1'b0;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    rdata_d  = '0;
    sdin_d   = '0;
    win      = (REQ_A && REQ_B) ? ~last_q : REQ_B;
    win_op   = win ? OP_B : OP_A;
    win_data = win ? WDATA_B : WDATA_A;

    case (state_q)
      IDLE: begin
        if (REQ_A || REQ_B) begin
          gnt_d   = win;
          last_d  = win;
          op_d    = win_op;
          wdata_d = win_data;
          if ((win_op && STK_FULL) || (!win_op && STK_EMPTY)) begin
            state_d = RESP;
            err_d   = 1'b1;
            ack_a_d = ~win;
            ack_b_d = win;
          end else begin
            state_d = CMD;
            push_d  = win_op;
            pop_d   = ~win_op;
            sdin_d  = win_op ? win_data : '0;
          end
        end
      end
      CMD:    state_d = SETTLE;
      SETTLE: begin
        // Response is loaded here so RDATA/ACK leave the flops together in RESP.
        state_d = RESP;
        rdata_d = op_q ? wdata_q : STK_DATA_OUT;
        ack_a_d = ~gnt_q;
        ack_b_d = gnt_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 1'b0;
      wdata_q <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      rdata_q <= '0;
      sdin_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      rdata_q <= rdata_d;
      sdin_q  <= sdin_d;
    end
  end

  assign ACK_A       = ack_a_q;
  assign ACK_B       = ack_b_q;
  assign RDATA       = rdata_q;
  assign ERR         = err_q;
  assign BUSY        = busy_q;
  assign STK_PUSH    = push_q;
  assign STK_POP     = pop_q;
  assign STK_DATA_IN = sdin_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter with a 4-deep behavioural stack attached.
module tb_stack_arbiter;
  localparam int DW = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ_A = 1'b0, REQ_B = 1'b0, OP_A = 1'b0, OP_B = 1'b0;
  logic [DW-1:0] WDATA_A = '0, WDATA_B = '0;
  logic          ACK_A, ACK_B, ERR, BUSY, STK_PUSH, STK_POP;
  logic [DW-1:0] RDATA, STK_DATA_IN;
  logic [DW-1:0] STK_DATA_OUT;
  logic          STK_FULL, STK_EMPTY;

  stack_arbiter #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .OP_A(OP_A), .OP_B(OP_B),
    .WDATA_A(WDATA_A), .WDATA_B(WDATA_B),
    .ACK_A(ACK_A), .ACK_B(ACK_B), .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY),
    .STK_PUSH(STK_PUSH), .STK_POP(STK_POP), .STK_DATA_IN(STK_DATA_IN),
    .STK_DATA_OUT(STK_DATA_OUT), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Stack model: pop result appears on STK_DATA_OUT the cycle after the strobe.
  logic [DW-1:0] mem [4];
  int            cnt = 0;
  logic [DW-1:0] sdout = '0;
  always @(posedge CLK) begin
    if (RST) begin
      cnt   <= 0;
      sdout <= '0;
    end else if (STK_PUSH && cnt < 4) begin
      mem[cnt] <= STK_DATA_IN;
      cnt      <= cnt + 1;
    end else if (STK_POP && cnt > 0) begin
      sdout <= mem[cnt-1];
      cnt   <= cnt - 1;
    end
  end
  assign STK_DATA_OUT = sdout;
  assign STK_FULL     = (cnt == 4);
  assign STK_EMPTY    = (cnt == 0);

  typedef struct { bit b; bit err; logic [DW-1:0] rd; int cyc; } ack_t;
  typedef struct { bit push; logic [DW-1:0] d; int cyc; } stb_t;
  ack_t ackq[$];
  stb_t stbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each ACK / strobe.
  always @(negedge CLK) begin
    ack_t a;
    stb_t s;
    checks++;
    if (STK_PUSH && STK_POP) begin
      errors++;
      $display("FAIL strobe_excl: push=%0b pop=%0b required not both", STK_PUSH, STK_POP);
    end
    checks++;
    if (ACK_A && ACK_B) begin
      errors++;
      $display("FAIL ack_excl: ack_a=%0b ack_b=%0b required not both", ACK_A, ACK_B);
    end
    if (!ACK_A && !ACK_B) begin
      checks++;
      if (RDATA !== '0 || ERR !== 1'b0) begin
        errors++;
        $display("FAIL idle_bus: cyc=%0d rdata=%0d err=%0b required 0/0", cyc, RDATA, ERR);
      end
    end else begin
      checks++;
      if (ackq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: cyc=%0d ack_a=%0b ack_b=%0b required none", cyc, ACK_A, ACK_B);
      end else begin
        a = ackq.pop_front();
        if (ACK_B !== a.b || ERR !== a.err || RDATA !== a.rd || cyc != a.cyc) begin
          errors++;
          $display("FAIL ack: got cyc=%0d B=%0b err=%0b rdata=%0d, expected cyc=%0d B=%0b err=%0b rdata=%0d",
                   cyc, ACK_B, ERR, RDATA, a.cyc, a.b, a.err, a.rd);
        end
      end
    end
    if (STK_PUSH || STK_POP) begin
      checks++;
      if (stbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: cyc=%0d push=%0b pop=%0b required none", cyc, STK_PUSH, STK_POP);
      end else begin
        s = stbq.pop_front();
        if (STK_PUSH !== s.push || cyc != s.cyc || (s.push && STK_DATA_IN !== s.d)) begin
          errors++;
          $display("FAIL strobe: got cyc=%0d push=%0b din=%0d, expected cyc=%0d push=%0b din=%0d",
                   cyc, STK_PUSH, STK_DATA_IN, s.cyc, s.push, s.d);
        end
      end
    end
  end

  // One request from a single requester; ACK awaited with a bounded wait.
  task automatic single(input bit b, input bit op, input logic [DW-1:0] wd,
                        input bit err, input logic [DW-1:0] rd);
    int e;
    bit got;
    @(posedge CLK); #1;
    if (b) begin REQ_B = 1'b1; OP_B = op; WDATA_B = wd; end
    else   begin REQ_A = 1'b1; OP_A = op; WDATA_A = wd; end
    e = cyc + 1;
    ackq.push_back('{b: b, err: err, rd: rd, cyc: err ? e : e + 2});
    if (!err) stbq.push_back('{push: op, d: wd, cyc: e});
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge CLK); #1;
      got = b ? ACK_B : ACK_A;
    end
    chk("ack_timeout", int'(got), 1);
    REQ_A = 1'b0;
    REQ_B = 1'b0;
  endtask

  // Both requesters push continuously; A wins the first tie, then alternation.
  task automatic both(input logic [DW-1:0] wa, input logic [DW-1:0] wb, input int n);
    int e;
    @(posedge CLK); #1;
    REQ_A = 1'b1; OP_A = 1'b1; WDATA_A = wa;
    REQ_B = 1'b1; OP_B = 1'b1; WDATA_B = wb;
    e = cyc + 1;
    for (int k = 0; k < n; k++) begin
      ackq.push_back('{b: k[0], err: 1'b0, rd: k[0] ? wb : wa, cyc: e + 2 + 4*k});
      stbq.push_back('{push: 1'b1, d: k[0] ? wb : wa, cyc: e + 4*k});
    end
    repeat (4*n - 1) @(posedge CLK);
    #1;
    REQ_A = 1'b0;
    REQ_B = 1'b0;
  endtask

  initial begin
    int e;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ack", int'({ACK_A, ACK_B}), 0);
    chk("rst_strobe", int'({STK_PUSH, STK_POP}), 0);
    chk("rst_rdata_err", int'({RDATA, ERR}), 0);
    chk("rst_din", int'(STK_DATA_IN), 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    single(1'b0, 1'b0, 2'b00, 1'b1, 2'b00);  // pop on empty -> error
    single(1'b0, 1'b1, 2'b10, 1'b0, 2'b10);  // push 10
    single(1'b0, 1'b1, 2'b01, 1'b0, 2'b01);  // push 01
    single(1'b0, 1'b0, 2'b11, 1'b0, 2'b01);  // pop -> 01
    single(1'b1, 1'b0, 2'b00, 1'b0, 2'b10);  // B pop -> 10

    @(posedge CLK); #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    both(2'b11, 2'b00, 4);                   // fills the stack
    single(1'b1, 1'b1, 2'b10, 1'b1, 2'b00);  // B push on full -> error

    // Abort a pop by reset while in SETTLE.
    @(posedge CLK); #1;
    REQ_A = 1'b1; OP_A = 1'b0;
    e = cyc + 1;
    stbq.push_back('{push: 1'b0, d: '0, cyc: e});
    @(posedge CLK);
    @(posedge CLK); #1;
    chk("settle_busy", int'(BUSY), 1);
    RST = 1'b1; REQ_A = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_busy", int'(BUSY), 0);
    both(2'b01, 2'b10, 2);                   // tie after reset goes to A

    repeat (6) @(posedge CLK);
    chk("ack_queue_empty", ackq.size(), 0);
    chk("strobe_queue_empty", stbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
